// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Consumers: muldiv_step, muldiv_seq.
package muldiv_pkg;

    // Control states of the iterative engine
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_e;

    // Number of shift-add / shift-subtract iterations
    localparam int unsigned MULDIV_ITER = 32;

    // Start edge to done-cycle distance, in clock edges
    localparam int unsigned MULDIV_LAT_FIXED = 34;
    localparam int unsigned MULDIV_LAT_EARLY = 2;

    // Quotient reported for a zero divisor
    localparam logic [31:0] MULDIV_DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of v when treated as signed, raw v otherwise
    function automatic logic [31:0] mag32(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// acc holds {P_hi, P_lo} for multiply and {remainder, quotient} for divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        op_div,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out
);

    logic [32:0] add_sum;
    logic [32:0] rem_shift;
    logic        rem_fits;
    logic [31:0] rem_diff;

    // Multiply: conditional add then shift right; divide: shift left then restoring subtract
    always_comb begin
        add_sum   = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
        rem_shift = {acc_in[63:32], acc_in[31]};
        // Remainder before shifting is below the divisor, so a successful
        // subtract always leaves a value that fits in 32 bits.
        rem_fits  = (rem_shift >= {1'b0, operand});
        rem_diff  = rem_shift[31:0] - operand;
        if (op_div) begin
            if (rem_fits) begin
                acc_out = {rem_diff, acc_in[30:0], 1'b1};
            end else begin
                acc_out = {rem_shift[31:0], acc_in[30:0], 1'b0};
            end
        end else begin
            acc_out = {add_sum, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide (MULT, MULTU, DIV, DIVU).
// Optional build macro: MULDIV_SEQ_EARLY_OUT_EN -- zero divisor or zero
// multiply operand skips the iteration loop and completes two edges after start.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic        op_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    muldiv_state_e state_reg, state_next;
    logic [5:0]    cnt_reg;
    logic          is_div_reg, signed_reg;
    logic [31:0]   a_raw_reg, b_raw_reg, operand_reg;
    logic          neg_res_reg, neg_rem_reg;
    logic [63:0]   acc_reg, acc_step, prod_fixed;
    logic [31:0]   hi_reg, lo_reg, res_hi, res_lo;
    logic          div_zero_reg;
    logic          start_any, b_zero, early_out, abort;
    logic [31:0]   a_mag, b_mag;

    assign start_any = mult_start | div_start;
    assign b_zero    = (b_raw_reg == 32'd0);
    assign abort     = cancel && (state_reg != IDLE);
    assign a_mag     = mag32(signed_reg, a_raw_reg);
    assign b_mag     = mag32(signed_reg, b_raw_reg);

`ifdef MULDIV_SEQ_EARLY_OUT_EN
    assign early_out = b_zero || (!is_div_reg && (a_raw_reg == 32'd0));
`else
    assign early_out = 1'b0;
`endif

    muldiv_step u_step (
        .op_div  (is_div_reg),
        .acc_in  (acc_reg),
        .operand (operand_reg),
        .acc_out (acc_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic; cancel wins over everything outside IDLE
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (start_any) state_next = PREP;
                // Early-out holds PREP one extra cycle so done lands after E2
                PREP: if (early_out) state_next = (cnt_reg == 6'd1) ? DONE : PREP;
                      else           state_next = RUN;
                RUN:  if (cnt_reg == 6'(MULDIV_ITER - 1)) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    // Sign correction and special-case results, consumed when hi/lo load
    always_comb begin
        prod_fixed = neg_res_reg ? (64'd0 - acc_reg) : acc_reg;
        if (is_div_reg) begin
            res_hi = neg_rem_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
            res_lo = neg_res_reg ? (32'd0 - acc_reg[31:0])  : acc_reg[31:0];
        end else begin
            res_hi = prod_fixed[63:32];
            res_lo = prod_fixed[31:0];
        end
        if (is_div_reg && b_zero) begin
            res_hi = a_raw_reg;
            res_lo = MULDIV_DIV0_LO;
        end else if (state_reg == PREP) begin
            res_hi = 32'd0;
            res_lo = 32'd0;
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg      <= 6'd0;
            is_div_reg   <= 1'b0;
            signed_reg   <= 1'b0;
            a_raw_reg    <= 32'd0;
            b_raw_reg    <= 32'd0;
            operand_reg  <= 32'd0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            acc_reg      <= 64'd0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            div_zero_reg <= 1'b0;
        end else if (abort) begin
            cnt_reg <= 6'd0;
        end else begin
            case (state_reg)
                IDLE: if (start_any) begin
                    is_div_reg   <= !mult_start;
                    signed_reg   <= op_signed;
                    a_raw_reg    <= op_a;
                    b_raw_reg    <= op_b;
                    cnt_reg      <= 6'd0;
                    div_zero_reg <= 1'b0;
                end
                PREP: begin
                    acc_reg     <= {32'd0, is_div_reg ? a_mag : b_mag};
                    operand_reg <= is_div_reg ? b_mag : a_mag;
                    neg_res_reg <= signed_reg && (a_raw_reg[31] ^ b_raw_reg[31]);
                    neg_rem_reg <= signed_reg && a_raw_reg[31];
                    cnt_reg     <= early_out ? (cnt_reg + 6'd1) : 6'd0;
                    if (early_out && (cnt_reg == 6'd1)) begin
                        hi_reg       <= res_hi;
                        lo_reg       <= res_lo;
                        div_zero_reg <= is_div_reg && b_zero;
                        cnt_reg      <= 6'd0;
                    end
                end
                RUN: begin
                    acc_reg <= acc_step;
                    cnt_reg <= (cnt_reg == 6'(MULDIV_ITER - 1)) ? 6'd0 : (cnt_reg + 6'd1);
                end
                FIX: begin
                    hi_reg       <= res_hi;
                    lo_reg       <= res_lo;
                    div_zero_reg <= is_div_reg && b_zero;
                end
                default: ;
            endcase
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signed/unsigned results,
// divide by zero, cancel, start collisions and mid-operation reset.
module tb_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        mult_start, div_start, op_signed, cancel;
    logic [31:0] op_a, op_b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

`ifdef MULDIV_SEQ_EARLY_OUT_EN
    localparam int DIV0_LAT = 2;
`else
    localparam int DIV0_LAT = 34;
`endif

    muldiv_seq dut (
        .clk        (clk),
        .rst        (rst),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_signed  (op_signed),
        .op_a       (op_a),
        .op_b       (op_b),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, follow it edge by edge and check the result.
    // poke > 0 drives div_start high at edge E<poke> while the unit is busy.
    task automatic run_op(input string tag, input bit m, input bit d, input bit s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit exp_dz, input int lat, input int poke);
        logic [63:0] prev;
        prev = {hi, lo};
        @(negedge clk);
        mult_start = m; div_start = d; op_signed = s; op_a = a; op_b = b;
        @(posedge clk); #1;
        mult_start = 0; div_start = 0;
        check({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);
        check({tag, "_dz_clear_e0"}, {63'd0, div_zero}, 64'd0);
        for (int i = 1; i <= lat; i++) begin
            div_start = (i == poke);
            @(posedge clk); #1;
            div_start = 0;
            if (i < lat) begin
                check({tag, "_wait_done"}, {63'd0, done}, 64'd0);
                check({tag, "_wait_busy"}, {63'd0, busy}, 64'd1);
                check({tag, "_hold_hilo"}, {hi, lo}, prev);
            end
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({tag, "_dz"}, {63'd0, div_zero}, {63'd0, exp_dz});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check({tag, "_after_done"}, {63'd0, done}, 64'd0);
            check({tag, "_after_busy"}, {63'd0, busy}, 64'd0);
        end
        check({tag, "_after_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        $display("op %s a=%h b=%h -> hi=%h lo=%h dz=%0d", tag, a, b, hi, lo, div_zero);
    endtask

    initial begin
        int done_cnt;
        rst = 0; mult_start = 0; div_start = 0; op_signed = 0; cancel = 0;
        op_a = 0; op_b = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dz", {63'd0, div_zero}, 64'd0);
        $display("reset: busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);
        @(negedge clk); rst = 1;

        // Main function
        run_op("multu_ffff_x2", 1, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 0, 34, 0);
        run_op("div_m7_2", 0, 1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34, 0);
        run_op("divu_100_7", 0, 1, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34, 0);
        run_op("div_5_0", 0, 1, 1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, DIV0_LAT, 0);
        run_op("mult_m3_5", 1, 0, 1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 34, 0);
        run_op("div_ovf", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 34, 0);

        // Cancel mid multiply at E10
        @(negedge clk);
        mult_start = 1; op_signed = 1; op_a = 32'd7; op_b = 32'd9;
        @(posedge clk); #1;
        mult_start = 0;
        for (int i = 1; i <= 9; i++) begin @(posedge clk); #1; end
        check("cancel_busy_e9", {63'd0, busy}, 64'd1);
        cancel = 1;
        @(posedge clk); #1;
        cancel = 0;
        check("cancel_busy_e10", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        check("cancel_busy_e11", {63'd0, busy}, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("cancel_no_done", 64'(done_cnt), 64'd0);
        check("cancel_hilo_kept", {hi, lo}, {32'd0, 32'h8000_0000});
        $display("cancel: busy=%0d hi=%h lo=%h dones=%0d", busy, hi, lo, done_cnt);
        run_op("divu_after_cancel", 0, 1, 0, 32'd1000, 32'd10, 32'd0, 32'd100, 0, 34, 0);

        // Both starts together plus div_start poked at E5
        run_op("both_start", 1, 1, 0, 32'd6, 32'd7, 32'd0, 32'd42, 0, 34, 5);

        // Reset mid divide at E20
        @(negedge clk);
        div_start = 1; op_signed = 0; op_a = 32'd77; op_b = 32'd5;
        @(posedge clk); #1;
        div_start = 0;
        for (int i = 1; i <= 20; i++) begin @(posedge clk); #1; end
        check("midrst_busy_pre", {63'd0, busy}, 64'd1);
        rst = 0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_dz", {63'd0, div_zero}, 64'd0);
        $display("midrst: busy=%0d hi=%h lo=%h", busy, hi, lo);
        @(negedge clk); rst = 1;
        run_op("divu_77_5", 0, 1, 0, 32'd77, 32'd5, 32'd2, 32'd15, 0, 34, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The module SHALL have port mult_start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 The module SHALL have port div_start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 The module SHALL have port op_signed, input, 1 bit: 1 selects signed (MULT/DIV), 0 selects unsigned (MULTU/DIVU); sampled with the start signal.
REQ-006 The module SHALL have port op_a, input, 32 bits: multiplicand or dividend (Rs); sampled with the start signal.
REQ-007 The module SHALL have port op_b, input, 32 bits: multiplier or divisor (Rt); sampled with the start signal.
REQ-008 The module SHALL have port cancel, input, 1 bit: synchronous abort of the operation in flight.
REQ-009 The module SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse; high exactly when hi/lo take the new result.
REQ-011 The module SHALL have port hi, output, 32 bits: product[63:32] or remainder.
REQ-012 The module SHALL have port lo, output, 32 bits: product[31:0] or quotient.
REQ-013 The module SHALL have port div_zero, output, 1 bit: registered flag set with done when the divisor is 0, cleared on the next accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, PREP, RUN, FIX and DONE, with transitions IDLE->PREP on an accepted start, PREP->RUN, RUN->FIX after 32 iterations, FIX->DONE and DONE->IDLE.
REQ-015 If mult_start and div_start are high in the same IDLE cycle, the multiply SHALL be accepted and div_start ignored.
REQ-016 Start pulses outside IDLE SHALL be ignored; no queuing.
REQ-017 PREP SHALL latch |op_a| and |op_b| when op_signed=1, or the raw operands when op_signed=0, and SHALL record the result signs.
REQ-018 RUN SHALL perform one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle, with a 6-bit iteration counter running 0..31.
REQ-019 FIX SHALL negate the product if the operand signs differ, negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
REQ-020 In DONE, hi/lo SHALL be updated and done SHALL be high for exactly 1 cycle.
REQ-021 Latency SHALL be: with start sampled at edge E0, done high in the cycle following edge E34.
REQ-022 hi/lo SHALL hold their last result in every other cycle and SHALL never show intermediate values.
REQ-023 Divide by zero SHALL run the full latency and produce lo=32'hFFFF_FFFF, hi=op_a unmodified, div_zero=1, independent of op_signed.
REQ-024 Signed overflow (op_a=32'h8000_0000, op_b=32'hFFFF_FFFF) SHALL produce lo=32'h8000_0000, hi=0.
REQ-025 cancel high in any non-IDLE state SHALL return the FSM to IDLE at the next edge, with no done, hi/lo/div_zero unchanged, and busy low in the following cycle; cancel in IDLE SHALL have no effect.
REQ-026 If cancel and start are high in the same IDLE cycle, the start SHALL be accepted.

Reset
REQ-027 While rst=0, the FSM SHALL be in IDLE, the counter 0, hi=0, lo=0, busy=0, done=0 and div_zero=0, immediately and independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-029 The macro MULDIV_SEQ_EARLY_OUT_EN SHALL, when defined, make PREP go directly to DONE when op_b=0 or (multiply and op_a=0), giving done in the cycle after E2 with the result values of REQ-023 or a zero product.
REQ-030 Without MULDIV_SEQ_EARLY_OUT_EN, every operation SHALL take the fixed latency of REQ-021.

Structure
REQ-031 Package muldiv_pkg SHALL hold the state enum, MULDIV_ITER=32, the latency constants and the div-by-zero result constant.
REQ-032 One sub-module, muldiv_step, SHALL hold the purely combinational single-iteration datapath: shift-add or restoring subtract, selected by an op bit.

Verification
REQ-033 The bench SHALL check: MULTU op_a=32'hFFFF_FFFF, op_b=2 -> done in the cycle after E34, hi=1, lo=32'hFFFF_FFFE, busy high for cycles E0..E34.
REQ-034 The bench SHALL check: DIV op_a=-7, op_b=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIVU 100/7 -> lo=14, hi=2.
REQ-035 The bench SHALL check: DIV op_a=5, op_b=0 -> lo=32'hFFFF_FFFF, hi=5, div_zero=1; with MULDIV_SEQ_EARLY_OUT_EN, done in the cycle after E2.
REQ-036 The bench SHALL check: MULT -> cancel at E10 -> busy=0 after E11, no done, hi/lo keep their previous values; a new DIVU then completes normally.
REQ-037 The bench SHALL check: mult_start and div_start together -> multiply result; div_start pulsed at E5 while busy -> ignored, exactly one done.
REQ-038 The bench SHALL check: rst driven low at E20 mid-divide -> all outputs 0 immediately; after release the FSM is in IDLE and accepts a new start.
